// File: rtl/carry_select_adder.sv
// N-bit carry-select adder with registered {co, sum}; 1-cycle latency (2 with CSA_INPUT_REG_EN), one op per cycle.
// No backpressure: out_valid pulses once per accepted op, and sum/co hold between ops.
module carry_select_adder #(
    parameter int N     = 3,
    parameter int BLOCK = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co,
    output logic         out_valid
);
    localparam int NB = (N + BLOCK - 1) / BLOCK;

    logic [N-1:0]  w_a;
    logic [N-1:0]  w_b;
    logic          w_ci;
    logic          w_vld;
    logic [N-1:0]  w_sum;
    logic [NB-1:0] w_bc;

    logic [N-1:0]  r_sum;
    logic          r_co;
    logic          r_out_vld;

`ifdef CSA_INPUT_REG_EN
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_ci;
    logic         r_in_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_ci     <= 1'b0;
            r_in_vld <= 1'b0;
        end else begin
            r_a      <= a;
            r_b      <= b;
            r_ci     <= ci;
            r_in_vld <= in_valid;
        end
    end

    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_ci  = r_ci;
    assign w_vld = r_in_vld;
`else
    assign w_a   = a;
    assign w_b   = b;
    assign w_ci  = ci;
    assign w_vld = in_valid;
`endif

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int LO = k * BLOCK;
        localparam int HI = ((k + 1) * BLOCK < N) ? (k + 1) * BLOCK - 1 : N - 1;
        localparam int W  = HI - LO + 1;

        logic [W:0]   w_c0;
        logic [W-1:0] w_s0;

        // Block 0 ripples from ci; upper blocks assume carry-in 0 on this chain.
        assign w_c0[0] = (k == 0) ? w_ci : 1'b0;

        for (genvar j = 0; j < W; j++) begin : g_fa0
            assign w_s0[j]   = w_a[LO+j] ^ w_b[LO+j] ^ w_c0[j];
            assign w_c0[j+1] = (w_a[LO+j] & w_b[LO+j]) | (w_c0[j] & (w_a[LO+j] ^ w_b[LO+j]));
        end

        if (k == 0) begin : g_first
            assign w_sum[HI:LO] = w_s0;
            assign w_bc[k]      = w_c0[W];
        end else begin : g_sel
            logic [W:0]   w_c1;
            logic [W-1:0] w_s1;

            assign w_c1[0] = 1'b1;

            for (genvar j = 0; j < W; j++) begin : g_fa1
                assign w_s1[j]   = w_a[LO+j] ^ w_b[LO+j] ^ w_c1[j];
                assign w_c1[j+1] = (w_a[LO+j] & w_b[LO+j]) | (w_c1[j] & (w_a[LO+j] ^ w_b[LO+j]));
            end

            assign w_sum[HI:LO] = w_bc[k-1] ? w_s1 : w_s0;
            assign w_bc[k]      = w_bc[k-1] ? w_c1[W] : w_c0[W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum     <= '0;
            r_co      <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= w_vld;
            if (w_vld) begin
                r_sum <= w_sum;
                r_co  <= w_bc[NB-1];
            end
        end
    end

    assign sum       = r_sum;
    assign co        = r_co;
    assign out_valid = r_out_vld;
endmodule

// File: tb/tb_carry_select_adder.sv
// Bench for carry_select_adder: a 3-bit/2-block instance and an 8-bit/3-block instance,
// each checked against a queue of expected {co, sum} values and a valid-timing model.
module tb_carry_select_adder;
`ifdef CSA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       v3, ci3, v8, ci8;
    logic [2:0] a3, b3;
    logic [7:0] a8, b8;
    logic [2:0] sum3;
    logic [7:0] sum8;
    logic       co3, co8, ov3, ov8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    carry_select_adder #(.N(3), .BLOCK(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .a(a3), .b(b3), .ci(ci3),
        .sum(sum3), .co(co3), .out_valid(ov3)
    );

    carry_select_adder #(.N(8), .BLOCK(3)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .ci(ci8),
        .sum(sum8), .co(co8), .out_valid(ov8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [3:0] q3[$];
    logic [8:0] q8[$];
    logic [1:0] pipe3 = 2'b00;
    logic [1:0] pipe8 = 2'b00;
    logic [3:0] held3 = '0;
    logic [8:0] held8 = '0;

    // Expected-result scoreboard for the 3-bit instance.
    always @(posedge clk) begin
        logic       ev;
        logic [3:0] e;
        if (rst) begin
            pipe3 = 2'b00;
            q3.delete();
            held3 = '0;
        end else begin
            pipe3 = {pipe3[0], v3};
            if (v3) q3.push_back(4'({1'b0, a3}) + 4'({1'b0, b3}) + 4'(ci3));
        end
        ev = pipe3[LAT-1];
        #1;
        check("vld3", ov3, ev);
        if (ev) begin
            if (q3.size() == 0) begin
                check("sb3_underflow", 1, 0);
            end else begin
                e = q3.pop_front();
                held3 = e;
            end
        end
        check("sum3", sum3, held3[2:0]);
        check("co3", co3, held3[3]);
    end

    // Expected-result scoreboard for the 8-bit instance.
    always @(posedge clk) begin
        logic       ev;
        logic [8:0] e;
        if (rst) begin
            pipe8 = 2'b00;
            q8.delete();
            held8 = '0;
        end else begin
            pipe8 = {pipe8[0], v8};
            if (v8) q8.push_back(9'({1'b0, a8}) + 9'({1'b0, b8}) + 9'(ci8));
        end
        ev = pipe8[LAT-1];
        #1;
        check("vld8", ov8, ev);
        if (ev) begin
            if (q8.size() == 0) begin
                check("sb8_underflow", 1, 0);
            end else begin
                e = q8.pop_front();
                held8 = e;
            end
        end
        check("sum8", sum8, held8[7:0]);
        check("co8", co8, held8[8]);
    end

    logic [6:0]  c3_tab [3] = '{7'b111_111_1, 7'b000_000_0, 7'b101_010_1};
    logic [16:0] c8_tab [3] = '{{8'hFF, 8'h01, 1'b0}, {8'h80, 8'h7F, 1'b1}, {8'hAA, 8'h55, 1'b1}};

    initial begin
        rst = 1'b1;
        v3 = 1'b0; a3 = '0; b3 = '0; ci3 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Exhaustive 3-bit sweep, back to back, with random traffic on the 8-bit instance.
        for (int i = 0; i < 128; i++) begin
            v3 = 1'b1;
            {a3, b3, ci3} = 7'(i);
            v8 = 1'b1;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            ci8 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        // Corner operands, including carries that cross every block boundary.
        for (int i = 0; i < 3; i++) begin
            {a3, b3, ci3} = c3_tab[i];
            {a8, b8, ci8} = c8_tab[i];
            @(negedge clk);
        end
        v8 = 1'b0;

        // Hold: result stays 4 while in_valid is low and operands change.
        a3 = 3'd3; b3 = 3'd1; ci3 = 1'b0; v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0; a3 = 3'd6; b3 = 3'd6;
        repeat (3) @(negedge clk);

        // Reset in the middle of back-to-back traffic; in_valid during reset is ignored.
        v3 = 1'b1; v8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a3 = 3'(i); b3 = 3'(7 - i); ci3 = 1'(i);
            a8 = 8'(i * 37); b8 = 8'(255 - i * 11); ci8 = 1'(i + 1);
            rst = (i == 3);
            @(negedge clk);
        end
        rst = 1'b0;
        v3 = 1'b0; v8 = 1'b0;

        // Operands registered at edge t surface after edge t+1 in the input-register build.
        a3 = 3'd6; b3 = 3'd3; ci3 = 1'b0; v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0; a3 = 3'd0; b3 = 3'd0;
        repeat (4) @(negedge clk);

        check("sb3_empty", q3.size(), 0);
        check("sb8_empty", q8.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
